fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 2, prefetch buffer entries (power of two, at least 2).
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port increment, input, 1, consumer takes the head word this cycle.
REQ-008 SHALL have port jump, input, 1, redirect the fetch stream.
REQ-009 SHALL have port jump_addr, input, ADDR_W, redirect target.
REQ-010 SHALL have port mem_req, output, 1, memory read request.
REQ-011 SHALL have port mem_addr, output, ADDR_W, memory read address.
REQ-012 SHALL have port mem_ack, input, 1, memory returns data this cycle.
REQ-013 SHALL have port mem_rdata, input, DATA_W, read data, valid when mem_ack=1.
REQ-014 SHALL have port word, output, DATA_W, head-of-buffer instruction to the control unit.
REQ-015 SHALL have port word_valid, output, 1, word holds a valid instruction.
REQ-016 SHALL have port pc, output, ADDR_W, address of the word currently presented.

Function
REQ-017 SHALL implement FSM states FETCH, WAIT_ACK and DISCARD.
REQ-018 FETCH: SHALL assert mem_req=1 with mem_addr=fetch_addr when the buffer holds fewer than DEPTH entries, then go to WAIT_ACK; otherwise stay in FETCH with mem_req=0.
REQ-019 WAIT_ACK: SHALL hold mem_req=1 with mem_addr stable until mem_ack=1.
REQ-020 On mem_ack=1 in WAIT_ACK, SHALL push mem_rdata into the buffer, increment fetch_addr modulo 2^ADDR_W, and return to FETCH.
REQ-021 SHALL have at most one outstanding request.
REQ-022 Buffer SHALL never overflow: a request issues only when a free slot is reserved.
REQ-023 word and word_valid SHALL come directly from the buffer head register.
REQ-024 A word pushed at edge N SHALL be visible on word at edge N with word_valid=1 (no extra latency).
REQ-025 increment=1 with word_valid=1 SHALL pop the head and advance pc by 1, wrapping 2^ADDR_W-1 to 0.
REQ-026 increment=1 with word_valid=0 SHALL be ignored.
REQ-027 Push and pop in the same cycle SHALL be legal; occupancy is then unchanged.
REQ-028 jump=1 SHALL flush the buffer (word_valid=0 next cycle) and load pc and fetch_addr from jump_addr.
REQ-029 jump=1 in WAIT_ACK without mem_ack SHALL move the FSM to DISCARD.
REQ-030 jump=1 in WAIT_ACK with mem_ack SHALL drop the returned data and go to FETCH.
REQ-031 DISCARD: SHALL keep mem_req=1 at the old address until mem_ack, drop that data, then go to FETCH.
REQ-032 jump SHALL take priority over increment and push in the same cycle.
REQ-033 A second jump during DISCARD SHALL update pc and fetch_addr and stay in DISCARD.

Reset
REQ-034 Reset SHALL force FETCH, empty buffer, word_valid=0, word=0, mem_req=0, mem_addr=RESET_PC, pc=RESET_PC, fetch_addr=RESET_PC.
REQ-035 Reset asserted mid-request SHALL abandon the transaction, with no data accepted afterwards.
REQ-036 SHALL assert mem_req at the first edge after rst_n deasserts.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding and the ADDR_W/DATA_W defaults shared with data_path and control_unit.
REQ-038 The prefetch buffer SHALL be one sub-module, fetch_fifo, with push, pop, flush, head, count and full.

Verification
REQ-039 Reset, then memory acking every request in 1 cycle with mem_rdata=addr+16'h1000, increment held 1 -> word sequence 0x1000, 0x1001, 0x1002 with pc=0,1,2.
REQ-040 increment held 0 -> exactly DEPTH=2 words fetched, mem_req=0 thereafter, word stays 0x1000.
REQ-041 jump=1, jump_addr=0x40 while WAIT_ACK, ack 3 cycles later -> stale data dropped, next mem_addr=0x40, word=0x1040, pc=0x40.
REQ-042 Fetch from pc=0xFF -> after pop, pc=0x00 and mem_addr wraps 0xFF to 0x00.
REQ-043 jump and increment asserted in the same cycle -> buffer flushed, pc=jump_addr, no pop effect.
REQ-044 rst_n pulsed low during WAIT_ACK -> all outputs at reset values; a late mem_ack is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch path: FSM encoding and default widths
// used by fetch_unit, data_path and control_unit.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_ACK = 2'd1,
    DISCARD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: small circular FIFO whose head entry is read straight
// from the storage registers, so a word written at an edge is presented
// immediately after that edge.
module fetch_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic                         push_ok;
  logic                         pop_ok;

  assign full = (count == CNT_W'(DEPTH));
  assign head = mem[rd_ptr];

  // A push into a full buffer is only allowed when a pop frees a slot
  // in the same cycle; a pop on an empty buffer is ignored.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && (!full || pop_ok);

  // Storage, pointers and occupancy; flush empties without touching data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps a small prefetch buffer filled from a
// single-outstanding-request memory port and presents the head word with
// its address to the control unit. Jumps flush the buffer; a request that
// is in flight at the time of a jump is completed and its data dropped.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              increment,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_PC);
  localparam int CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              push;
  logic              pop;

  // Jump wins over both the returning data and the consumer's pop.
  assign push       = (state == WAIT_ACK) && mem_ack && !jump;
  assign pop        = increment && word_valid && !jump;
  assign word_valid = (fifo_count != '0);

  fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (jump),
    .din   (mem_rdata),
    .head  (word),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Request FSM. A request is only launched from FETCH with the buffer not
  // full, and no push can happen while in FETCH, so the free slot is
  // guaranteed when the data comes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      mem_req    <= 1'b0;
      mem_addr   <= RST_ADDR;
      fetch_addr <= RST_ADDR;
    end else begin
      case (state)
        FETCH: begin
          if (jump) begin
            // Buffer is being flushed, so there is room: go straight
            // to the new target.
            fetch_addr <= jump_addr;
            mem_req    <= 1'b1;
            mem_addr   <= jump_addr;
            state      <= WAIT_ACK;
          end else if (!fifo_full) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
            state    <= WAIT_ACK;
          end else begin
            mem_req <= 1'b0;
          end
        end
        WAIT_ACK: begin
          if (jump)
            fetch_addr <= jump_addr;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= FETCH;
            if (!jump)
              fetch_addr <= fetch_addr + 1'b1;
          end else if (jump) begin
            // Memory still owes us this transaction; keep the request
            // stable and throw the data away when it arrives.
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (jump)
            fetch_addr <= jump_addr;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= FETCH;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= FETCH;
        end
      endcase
    end
  end

  // Address of the presented word: follows pops and jumps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RST_ADDR;
    else if (jump)
      pc <= jump_addr;
    else if (pop)
      pc <= pc + 1'b1;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a simple memory responder returning
// 16'h1000 + address after a programmable number of wait cycles.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        increment;
  logic        jump;
  logic [7:0]  jump_addr;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] word;
  logic        word_valid;
  logic [7:0]  pc;

  int total = 0;
  int bad   = 0;

  // responder controls
  logic ack_en    = 1'b0;
  logic force_ack = 1'b0;
  int   ack_lat   = 0;
  int   wait_cnt  = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .increment  (increment),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .word       (word),
    .word_valid (word_valid),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  // Memory model: updates just after the falling edge so controls written
  // at that edge by the tests are already visible.
  always @(negedge clk) begin
    #1;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hBEEF;
    end else if (ack_en && mem_req) begin
      if (wait_cnt >= ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'h1000 + {8'h00, mem_addr};
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; increment = 1'b0; jump = 1'b0; jump_addr = 8'h00;
    ack_en = 1'b0; force_ack = 1'b0; ack_lat = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; increment = 1'b0; jump = 1'b0; jump_addr = 8'h00;
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b0)     begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_addr !== 8'h00)   begin bad++; $display("FAIL rst_mem_addr got=%h exp=00", mem_addr); end
    total++; if (word !== 16'h0000)    begin bad++; $display("FAIL rst_word got=%h exp=0000", word); end
    total++; if (word_valid !== 1'b0)  begin bad++; $display("FAIL rst_word_valid got=%b exp=0", word_valid); end
    total++; if (pc !== 8'h00)         begin bad++; $display("FAIL rst_pc got=%h exp=00", pc); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1)     begin bad++; $display("FAIL first_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 8'h00)   begin bad++; $display("FAIL first_addr got=%h exp=00", mem_addr); end
  endtask

  task automatic test_sequence();
    int k = 0;
    do_reset();
    ack_en = 1'b1; ack_lat = 0; increment = 1'b1;
    for (int i = 0; i < 30 && k < 3; i++) begin
      @(negedge clk);
      if (word_valid === 1'b1) begin
        total++; if (word !== 16'h1000 + 16'(k)) begin bad++; $display("FAIL seq_word%0d got=%h exp=%h", k, word, 16'h1000 + 16'(k)); end
        total++; if (pc !== 8'(k))               begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", k, pc, 8'(k)); end
        k++;
      end
    end
    total++; if (k != 3) begin bad++; $display("FAIL seq_timeout got=%0d words exp=3", k); end
    increment = 1'b0;
  endtask

  task automatic test_hold();
    int reqs = 0;
    logic prev = 1'b0;
    do_reset();
    ack_en = 1'b1; ack_lat = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (mem_req && !prev) reqs++;
      prev = mem_req;
    end
    total++; if (reqs != 2)           begin bad++; $display("FAIL hold_reqs got=%0d exp=2", reqs); end
    total++; if (mem_req !== 1'b0)    begin bad++; $display("FAIL hold_mem_req got=%b exp=0", mem_req); end
    total++; if (word !== 16'h1000)   begin bad++; $display("FAIL hold_word got=%h exp=1000", word); end
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", word_valid); end
    total++; if (pc !== 8'h00)        begin bad++; $display("FAIL hold_pc got=%h exp=00", pc); end
  endtask

  task automatic test_jump_wait();
    do_reset();
    @(negedge clk);                       // request to 0x00 outstanding
    jump = 1'b1; jump_addr = 8'h40;
    @(negedge clk);
    jump = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin bad++; $display("FAIL disc_hold got=%b/%h exp=1/00", mem_req, mem_addr); end
    total++; if (pc !== 8'h40)         begin bad++; $display("FAIL disc_pc got=%h exp=40", pc); end
    total++; if (word_valid !== 1'b0)  begin bad++; $display("FAIL disc_valid got=%b exp=0", word_valid); end
    ack_lat = 2; ack_en = 1'b1;
    for (int i = 0; i < 10 && mem_req; i++) @(negedge clk);
    total++; if (mem_req !== 1'b0)     begin bad++; $display("FAIL disc_timeout got=%b exp=0", mem_req); end
    total++; if (word_valid !== 1'b0)  begin bad++; $display("FAIL disc_stale got=%b exp=0", word_valid); end
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin bad++; $display("FAIL jump_addr got=%b/%h exp=1/40", mem_req, mem_addr); end
    for (int i = 0; i < 10 && !word_valid; i++) @(negedge clk);
    total++; if (word_valid !== 1'b1)  begin bad++; $display("FAIL jump_word_timeout got=%b exp=1", word_valid); end
    total++; if (word !== 16'h1040)    begin bad++; $display("FAIL jump_word got=%h exp=1040", word); end
    total++; if (pc !== 8'h40)         begin bad++; $display("FAIL jump_pc got=%h exp=40", pc); end
  endtask

  task automatic test_wrap_and_jump_inc();
    do_reset();
    ack_en = 1'b1; ack_lat = 0;
    jump = 1'b1; jump_addr = 8'hFF;
    @(negedge clk);
    jump = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'hFF) begin bad++; $display("FAIL wrap_req got=%b/%h exp=1/ff", mem_req, mem_addr); end
    repeat (2) @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin bad++; $display("FAIL wrap_addr got=%b/%h exp=1/00", mem_req, mem_addr); end
    total++; if (word !== 16'h10FF || pc !== 8'hFF)      begin bad++; $display("FAIL wrap_head got=%h/%h exp=10ff/ff", word, pc); end
    @(negedge clk);
    increment = 1'b1;
    @(negedge clk);
    increment = 1'b0;
    total++; if (pc !== 8'h00)        begin bad++; $display("FAIL wrap_pc got=%h exp=00", pc); end
    total++; if (word !== 16'h1000 || word_valid !== 1'b1) begin bad++; $display("FAIL wrap_word got=%h/%b exp=1000/1", word, word_valid); end
    // jump and increment together: flush wins, no pop
    jump = 1'b1; jump_addr = 8'h20; increment = 1'b1;
    @(negedge clk);
    jump = 1'b0; increment = 1'b0;
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL ji_flush got=%b exp=0", word_valid); end
    total++; if (pc !== 8'h20)        begin bad++; $display("FAIL ji_pc got=%h exp=20", pc); end
    @(negedge clk);
    total++; if (word !== 16'h1020 || pc !== 8'h20 || word_valid !== 1'b1) begin bad++; $display("FAIL ji_word got=%h/%h/%b exp=1020/20/1", word, pc, word_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    total++; if (mem_req !== 1'b1)    begin bad++; $display("FAIL mid_pre got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || mem_addr !== 8'h00) begin bad++; $display("FAIL mid_req got=%b/%h exp=0/00", mem_req, mem_addr); end
    total++; if (word !== 16'h0 || word_valid !== 1'b0 || pc !== 8'h00) begin bad++; $display("FAIL mid_out got=%h/%b/%h exp=0000/0/00", word, word_valid, pc); end
    force_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL late_ack got=%b exp=0", word_valid); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin bad++; $display("FAIL mid_restart got=%b/%h exp=1/00", mem_req, mem_addr); end
    repeat (2) @(negedge clk);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL late_ack2 got=%b exp=0", word_valid); end
  endtask

  initial begin
    rst_n = 1'b0; increment = 1'b0; jump = 1'b0; jump_addr = 8'h00;
    test_reset();
    test_sequence();
    test_hold();
    test_jump_wait();
    test_wrap_and_jump_inc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
